spw_rx_credit_fifo: RTL

//  Receive-side N-char buffer sitting directly downstream of the SpaceWire RX path.
//  - Stores every received N-char (rx data/flag on buffer_write) in a show-ahead FIFO for the host.
//  - Tracks the credit granted to the link partner and requests FCTs from the TX path (send_fct_now).
//  - Flags credit violations (credit_error_rx to the link FSM).

---
 rtl/spw_rx_credit_fifo.sv | 111 +++++++++++
 1 files changed

// File: rtl/spw_rx_credit_fifo.sv
// rtl/spw_rx_credit_fifo.sv - SpaceWire receive N-char FIFO with link credit tracking and FCT requests
module spw_rx_credit_fifo #(
    parameter int DEPTH   = 64,
    parameter int DATA_W  = 9,
    parameter int HOLDOFF = 16
) (
    input  logic                       pclk,
    input  logic                       resetn,
    input  logic                       link_up,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_en,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       rd_valid,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       send_fct_now,
    output logic                       credit_error,
    output logic                       overflow
);

    localparam int PTR_W      = $clog2(DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int HO_W       = $clog2(HOLDOFF + 1);
    localparam int FCT_CREDIT = 8;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [5:0]        credit;
    logic [HO_W-1:0]   holdoff;

    logic empty;
    logic full;
    logic do_pop;
    logic do_write;
    logic credit_avail;
    logic room_for_fct;
    logic fct_issue;

    assign empty        = (count == '0);
    assign full         = (count == CNT_W'(DEPTH));
    assign do_pop       = rd_en && !empty;
    // A full FIFO still accepts a write when the same cycle frees a slot.
    assign do_write     = wr_en && (!full || do_pop);
    assign credit_avail = (credit != 6'd0);

    // Grant more credit only if the partner could never overrun the buffer with it.
    assign room_for_fct = (32'(count) + 32'(credit) + 32'(FCT_CREDIT)) <= 32'(DEPTH);
    assign fct_issue    = link_up && (holdoff == '0) && (credit <= 6'd48) && room_for_fct;

    assign rd_valid   = !empty;
    assign rd_data    = empty ? '0 : mem[rd_ptr];
    assign fifo_count = count;

    always_ff @(posedge pclk) begin
        if (do_write) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_write && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (do_pop && !do_write) begin
                count <= count - CNT_W'(1);
            end
            if (wr_en && !do_write) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge pclk or negedge resetn) begin
        if (!resetn) begin
            credit       <= '0;
            holdoff      <= '0;
            send_fct_now <= 1'b0;
            credit_error <= 1'b0;
        end else begin
            send_fct_now <= fct_issue;
            credit_error <= wr_en && !credit_avail;
            if (!link_up) begin
                credit  <= '0;
                holdoff <= '0;
            end else begin
                credit <= credit - {5'd0, (wr_en && credit_avail)}
                                 + (fct_issue ? 6'(FCT_CREDIT) : 6'd0);
                // Reload with HOLDOFF-1 so consecutive pulses land exactly HOLDOFF cycles apart.
                if (fct_issue) begin
                    holdoff <= HO_W'(HOLDOFF - 1);
                end else if (holdoff != '0) begin
                    holdoff <= holdoff - HO_W'(1);
                end
            end
        end
    end

endmodule
